// File: rtl/dmem_stage_ctrl.sv
// MEM-stage data-memory controller: word memory with fixed access latency.
// Stalls upstream for LATENCY cycles per access, presents registered load data in DONE.
module dmem_stage_ctrl #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_wr;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_stall;
    logic               w_commit;
    logic [31:0]        w_acc_addr;
    logic [31:0]        w_acc_wdata;
    logic               w_acc_wr;
    logic [ADDR_W-1:0]  w_idx;
    logic               w_err;

    assign w_req = MemRead_i | MemWrite_i;

    // A LATENCY=1 access commits on the request edge, before the latches exist.
    assign w_acc_addr  = (r_state == S_IDLE) ? addr_i     : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata_i    : r_wdata;
    assign w_acc_wr    = (r_state == S_IDLE) ? MemWrite_i : r_wr;
    assign w_idx       = w_acc_addr[ADDR_W+1:2];
    assign w_err       = (|w_acc_addr[1:0]) | (|w_acc_addr[31:ADDR_W+2]);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    if (LATENCY > 1) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CNT_INIT;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_commit    = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            // The instruction is still presented during DONE; never restart from here.
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign stall_o = w_stall & rst_n_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && w_req) begin
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_wr    <= MemWrite_i;
            end
            err_o <= w_commit & w_err;
            if (w_commit && !w_acc_wr) begin
                rdata_o <= w_err ? 32'h0 : r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit && w_acc_wr && !w_err) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Bench for dmem_stage_ctrl: directed vector table, reset/idle sequences, random traffic
// against a word-level memory model, plus a LATENCY=1 build.
module tb_dmem_stage_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, err;

    logic        rd1, wr1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata1;
    logic        stall1, err1;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_mem [32];
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    dmem_stage_ctrl #(.DEPTH(32), .ADDR_W(5), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .MemRead_i(rd), .MemWrite_i(wr),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .stall_o(stall), .err_o(err)
    );

    dmem_stage_ctrl #(.DEPTH(32), .ADDR_W(5), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
        .addr_i(addr1), .wdata_i(wdata1), .rdata_o(rdata1), .stall_o(stall1), .err_o(err1)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] r;
    } vec_t;

    vec_t tab [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_rdata = '0;
    endtask

    // Entered just after a rising edge; returns just after the edge ending DONE.
    task automatic access(input logic r_, input logic w_, input logic [31:0] a, input logic [31:0] d,
                          input logic use_tab, input logic te, input logic [31:0] tr, input string nm);
        logic bad;
        int   nst;
        logic done;
        bad = (a[1:0] != 2'b00) || (a[31:7] != '0);
        if (w_) begin
            if (!bad) m_mem[a[6:2]] = d;
        end else begin
            m_rdata = bad ? 32'h0 : m_mem[a[6:2]];
        end
        rd = r_; wr = w_; addr = a; wdata = d;
        nst = 0; done = 1'b0;
        for (int c = 0; c < LAT + 4 && !done; c++) begin
            @(negedge clk);
            if (stall) nst++;
            else done = 1'b1;
        end
        chk({nm, " stall_cycles"}, nst, LAT);
        chk({nm, " err"}, {31'h0, err}, use_tab ? {31'h0, te} : {31'h0, bad});
        chk({nm, " rdata"}, rdata, use_tab ? tr : m_rdata);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle_cycle(input string nm, input logic [31:0] a);
        addr = a; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk({nm, " stall"}, {31'h0, stall}, 32'h0);
        chk({nm, " err"}, {31'h0, err}, 32'h0);
        chk({nm, " rdata"}, rdata, m_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        tab[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        tab[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tab[2]  = '{1'b0, 1'b1, 32'h04,  32'h11111111, 1'b0, 32'hDEADBEEF};
        tab[3]  = '{1'b0, 1'b1, 32'h08,  32'h22222222, 1'b0, 32'hDEADBEEF};
        tab[4]  = '{1'b1, 1'b0, 32'h04,  32'h0,        1'b0, 32'h11111111};
        tab[5]  = '{1'b1, 1'b0, 32'h08,  32'h0,        1'b0, 32'h22222222};
        tab[6]  = '{1'b0, 1'b1, 32'h12,  32'h5,        1'b1, 32'h22222222};
        tab[7]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        tab[8]  = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0};
        tab[9]  = '{1'b1, 1'b0, 32'h7C,  32'h0,        1'b0, 32'h0};
        tab[10] = '{1'b1, 1'b0, 32'h80,  32'h0,        1'b1, 32'h0};
        tab[11] = '{1'b1, 1'b1, 32'h0C,  32'h77,       1'b0, 32'h0};
        tab[12] = '{1'b1, 1'b0, 32'h0C,  32'h0,        1'b0, 32'h77};

        rst_n = 1'b0;
        rd = 0; wr = 0; addr = 0; wdata = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        model_reset();
        #12;
        chk("reset stall", {31'h0, stall}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, issued back to back
        for (int i = 0; i < 13; i++) begin
            access(tab[i].rd, tab[i].wr, tab[i].a, tab[i].d, 1'b1, tab[i].e, tab[i].r,
                   $sformatf("vec%0d", i));
        end

        // Non-memory traffic must not stall or disturb rdata
        for (int i = 0; i < 10; i++) idle_cycle($sformatf("idle%0d", i), $urandom);
        chk("idle rdata held", rdata, 32'h77);

        // Reset during the second BUSY cycle of a store
        wr = 1'b1; addr = 32'h20; wdata = 32'hABCD;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wr = 1'b0;
        #1;
        chk("midrst stall", {31'h0, stall}, 32'h0);
        chk("midrst rdata", rdata, 32'h0);
        chk("midrst err", {31'h0, err}, 32'h0);
        model_reset();
        #5;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, "lw_after_rst");
        access(1'b1, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 32'h0, "lw_cleared");

        // Random traffic against the model
        for (int n = 0; n < 150; n++) begin
            int          kind;
            int          op;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            if (kind == 8) a[1:0] = 2'($urandom_range(1, 3));
            if (kind == 9) a[31:7] = 25'($urandom_range(1, 32'h1FFFFFF));
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, a, $urandom, 1'b0, 1'b0, 32'h0, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rgap%0d", n), $urandom);
        end

        // LATENCY=1 build: combined read/write commits as a write, then read it back
        rd1 = 1'b1; wr1 = 1'b1; addr1 = 32'h14; wdata1 = 32'h1234;
        @(negedge clk);
        chk("lat1 wr stall", {31'h0, stall1}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1 wr done stall", {31'h0, stall1}, 32'h0);
        chk("lat1 wr err", {31'h0, err1}, 32'h0);
        chk("lat1 wr rdata held", rdata1, 32'h0);
        @(posedge clk); #1;
        rd1 = 1'b1; wr1 = 1'b0; addr1 = 32'h14;
        @(negedge clk);
        chk("lat1 rd stall", {31'h0, stall1}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1 rd done stall", {31'h0, stall1}, 32'h0);
        chk("lat1 rd rdata", rdata1, 32'h1234);
        @(posedge clk); #1;
        rd1 = 1'b0;
        @(negedge clk);
        chk("lat1 idle stall", {31'h0, stall1}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
